fifo_wr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   state_t        : arbiter FSM states (IDLE = arbitration cycle, BURST = owner writing)
//   DATA_W         : data word width of the dual-clock FIFO write port
//   DEF_MAX_BURST  : default number of words per grant before forced rotation
//   idx_w()        : width of a requester index, max(1, clog2(n))
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DATA_W        = 11;
  localparam int DEF_MAX_BURST = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches req starting one position after `last`, wrapping modulo N (N need
// not be a power of two), and returns the first set bit.
//   req    [N-1:0]  : request vector
//   last   [IW-1:0] : index of the previous owner (search starts after it)
//   winner [IW-1:0] : index of the chosen requester (0 when none)
//   valid           : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // k runs 1..N so the previous owner is examined last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!valid && req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of the dual-clock FIFO
// among N requesters in the write-clock domain. One owner at a time writes a
// burst of up to MAX_BURST words; a single IDLE cycle separates bursts.
// Optional build macro: ARB_STATS_EN adds the stall_cnt output.
// Ports:
//   wr_clk      : write-domain clock
//   rst         : synchronous active-high reset
//   req         : per-requester request, held with its data until ack
//   data_in     : packed lanes, lane i = data_in[i*W +: W]
//   ack         : one-hot, combinational; lane i's word is written this edge
//   wr_full     : FIFO full flag, blocks all writes while high
//   fifo_wr_en  : FIFO write enable (= |ack)
//   fifo_data   : data lane of the current owner
//   grant_id    : registered index of the current/last owner
//   busy        : registered, high while in BURST
//   stall_cnt   : (ARB_STATS_EN only) saturating count of full-stalled cycles
module fifo_wr_arbiter
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW       = idx_w(N)
) (
  input  logic            wr_clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_in,
  output logic [N-1:0]    ack,
  input  logic            wr_full,
  output logic            fifo_wr_en,
  output logic [W-1:0]    fifo_data,
`ifdef ARB_STATS_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  state_t        state_reg, state_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [3:0]    burst_cnt_reg, burst_cnt_next;

  logic [N-1:0]  own_vec;
  logic [W-1:0]  lane_sel [N];
  logic          owner_req;
  logic [IW-1:0] pick_winner;
  logic          pick_valid;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .last   (grant_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Per-lane owner decode; avoids a dynamic index when N is not a power of two.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign own_vec[gi]  = (grant_reg == IW'(gi));
      assign lane_sel[gi] = own_vec[gi] ? data_in[gi*W +: W] : '0;
      assign ack[gi]      = ~rst & (state_reg == BURST) & own_vec[gi]
                            & req[gi] & ~wr_full;
    end
  endgenerate

  assign owner_req  = |(req & own_vec);
  assign fifo_wr_en = |ack;
  assign grant_id   = grant_reg;
  assign busy       = (state_reg == BURST);

  always_comb begin
    fifo_data = '0;
    for (int k = 0; k < N; k++) begin
      fifo_data = fifo_data | lane_sel[k];
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next     = pick_winner;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (!owner_req) begin
          // Withdrawal ends the burst without a write.
          state_next = IDLE;
        end else if (!wr_full) begin
          burst_cnt_next = burst_cnt_reg + 4'd1;
          if (burst_cnt_reg == 4'(MAX_BURST - 1)) begin
            state_next = IDLE;
          end
        end
        // owner_req with wr_full: stall, everything held.
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= IW'(N - 1);  // so requester 0 is searched first
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == BURST) && owner_req && wr_full
                 && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N=4, W=11, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next rising edge.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int IW = 2;

  logic          wr_clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]  ack;
  logic          wr_full;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data;
  logic [IW-1:0] grant_id;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .N         (N),
    .W         (W),
    .MAX_BURST (4)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .wr_full    (wr_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
`ifdef ARB_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; wr_full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] lane_val(input int lane, input int c);
    return W'(lane * 256 + c * 3 + 5);
  endfunction

  task automatic set_lanes(input int c);
    for (int i = 0; i < N; i++) data_in[i*W +: W] = lane_val(i, c);
  endtask

  // Reset asserted while lane 2 is mid-burst.
  task automatic test_reset();
    do_reset();
    req = 4'b0100; set_lanes(0);
    tick();                      // IDLE -> BURST on lane 2
    tick();                      // one word written
    rst = 1'b1; #1;
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack_gated ack=%b exp=0000", ack); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en_gated wr_en=%b exp=0", fifo_wr_en); end
    tick();
    rst = 1'b0; req = 4'b1111; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy busy=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant grant_id=%0d exp=3", grant_id); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_idle_ack ack=%b exp=0000", ack); end
    tick(); #1;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_first_grant grant_id=%0d exp=0", grant_id); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rst_first_ack ack=%b exp=0001", ack); end
    $display("test_reset done");
  endtask

  // Lone requester: 4 writes per 5 cycles.
  task automatic test_single();
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      set_lanes(c); #1;
      exp_ack = (c % 5 != 0) ? 4'b0100 : 4'b0000;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL single_ack cyc=%0d ack=%b exp=%b", c, ack, exp_ack); end
      checks++; if (busy !== (c % 5 != 0)) begin errors++; $display("FAIL single_busy cyc=%0d busy=%b exp=%b", c, busy, (c % 5 != 0)); end
      if (c % 5 != 0) begin
        checks++; if (fifo_data !== lane_val(2, c)) begin errors++; $display("FAIL single_data cyc=%0d data=%h exp=%h", c, fifo_data, lane_val(2, c)); end
        $display("write cyc=%0d lane=2 data=%h", c, fifo_data);
      end
      tick();
    end
  endtask

  // All lanes requesting: owners 0,1,2,3,0, four words each.
  task automatic test_round_robin();
    int b, p, own, exp_gid;
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      set_lanes(c); #1;
      b = c / 5; p = c % 5; own = b % 4;
      if (p == 0) begin
        exp_ack = 4'b0000;
        exp_gid = (b == 0) ? 3 : (b - 1) % 4;
      end else begin
        exp_ack = 4'(1 << own);
        exp_gid = own;
      end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_ack cyc=%0d ack=%b exp=%b", c, ack, exp_ack); end
      checks++; if (grant_id !== IW'(exp_gid)) begin errors++; $display("FAIL rr_grant cyc=%0d grant_id=%0d exp=%0d", c, grant_id, exp_gid); end
      if (p != 0) begin
        checks++; if (fifo_data !== lane_val(own, c)) begin errors++; $display("FAIL rr_data cyc=%0d data=%h exp=%h", c, fifo_data, lane_val(own, c)); end
        $display("write cyc=%0d lane=%0d data=%h", c, own, fifo_data);
      end
      tick();
    end
  endtask

  // Lane 1 stalled by wr_full for 3 cycles after 2 words.
  task automatic test_back_pressure();
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b0010; set_lanes(0);
    for (int c = 0; c < 9; c++) begin
      wr_full = (c >= 3 && c <= 5); #1;
      exp_ack = (c == 1 || c == 2 || c == 6 || c == 7) ? 4'b0010 : 4'b0000;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL bp_ack cyc=%0d ack=%b exp=%b", c, ack, exp_ack); end
      checks++; if (fifo_wr_en !== (exp_ack != 0)) begin errors++; $display("FAIL bp_wr_en cyc=%0d wr_en=%b exp=%b", c, fifo_wr_en, (exp_ack != 0)); end
      checks++; if (busy !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL bp_busy cyc=%0d busy=%b exp=%b", c, busy, (c >= 1 && c <= 7)); end
      tick();
    end
`ifdef ARB_STATS_EN
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt stall_cnt=%0d exp=3", stall_cnt); end
`endif
    $display("test_back_pressure done");
  endtask

  // Lane 3 withdraws after one word; lane 0 wins next via wrap-around.
  task automatic test_withdrawal();
    do_reset();
    req = 4'b1000; set_lanes(1);
    tick();                                   // grant lane 3
    req = 4'b1001; #1;
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wd_first_ack ack=%b exp=1000", ack); end
    tick();
    req = 4'b0001; #1;
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wd_drop_ack ack=%b exp=0000", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_drop_busy busy=%b exp=1", busy); end
    tick(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle_busy busy=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL wd_idle_grant grant_id=%0d exp=3", grant_id); end
    tick(); #1;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL wd_wrap_grant grant_id=%0d exp=0", grant_id); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wd_wrap_ack ack=%b exp=0001", ack); end
    $display("test_withdrawal done");
  endtask

  // FIFO already full when lane 1 is granted.
  task automatic test_full_at_grant();
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b0010; wr_full = 1'b1; set_lanes(2);
    for (int c = 0; c < 8; c++) begin
      wr_full = (c < 3); #1;
      exp_ack = (c >= 3 && c <= 6) ? 4'b0010 : 4'b0000;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL fg_ack cyc=%0d ack=%b exp=%b", c, ack, exp_ack); end
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fg_busy busy=%b exp=1", busy); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL fg_grant grant_id=%0d exp=1", grant_id); end
      end
      tick();
    end
    $display("test_full_at_grant done");
  endtask

  initial begin
    rst = 1'b1; req = '0; wr_full = 1'b0; data_in = '0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_withdrawal();
    test_full_at_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
